alu_issue_stage: RTL

ID/EX issue stage sitting directly upstream of the 32-bit MIPS ALU. Accepts decoded instruction fields and register-file operands, and generates the ALU 4-bit Control code. Selects and extends the immediate, applies EX/MEM forwarding, and presents registered operands to the ALU through a 2-entry valid/ready buffer so the ALU side can stall without combinational ready paths back to decode.

---
 rtl/alu_issue_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for a 32-bit MIPS ALU: decodes to the ALU control code, resolves
// operands with EX/MEM forwarding, and presents them through a 2-entry skid buffer.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rs_idx,
  input  logic [4:0]       rt_idx,
  input  logic [4:0]       rd_idx,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [15:0]      imm16,
  input  logic             fwd_en,
  input  logic [4:0]       fwd_idx,
  input  logic [WIDTH-1:0] fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       dest_idx,
  output logic             reg_write,
  output logic             is_branch,
  output logic             illegal_op,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_e;

  typedef struct packed {
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       dest;
    logic             rw;
    logic             br;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

  logic             legal;
  entry_t           new_ent;
  logic [WIDTH-1:0] rs_val, rt_val, imm_sext, imm_zext;
  logic             accept, push, pop;

  assign in_ready = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept = in_valid & in_ready;
  assign push = accept & legal;
  assign pop = out_valid & out_ready;

  // Register 0 is hard-wired to zero, so it must never pick up a forwarded value.
  always_comb begin
    rs_val = rs_data;
    if (rs_idx == 5'd0) rs_val = '0;
    else if (fwd_en && (fwd_idx == rs_idx)) rs_val = fwd_data;
    rt_val = rt_data;
    if (rt_idx == 5'd0) rt_val = '0;
    else if (fwd_en && (fwd_idx == rt_idx)) rt_val = fwd_data;
    imm_sext = {{(WIDTH-16){imm16[15]}}, imm16};
    imm_zext = {{(WIDTH-16){1'b0}}, imm16};
  end

  always_comb begin
    legal = 1'b1;
    new_ent = '0;
    new_ent.a = rs_val;
    unique case (opcode)
      6'h00: begin
        new_ent.b = rt_val;
        new_ent.dest = rd_idx;
        new_ent.rw = 1'b1;
        unique case (funct)
          6'h24: new_ent.ctrl = 4'b0000;
          6'h25: new_ent.ctrl = 4'b0001;
          6'h20: new_ent.ctrl = 4'b0010;
          6'h22: new_ent.ctrl = 4'b0110;
          6'h2A: new_ent.ctrl = 4'b0111;
          6'h27: new_ent.ctrl = 4'b1100;
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin new_ent.ctrl = 4'b0010; new_ent.b = imm_sext; new_ent.dest = rt_idx; new_ent.rw = 1'b1; end
      6'h0A: begin new_ent.ctrl = 4'b0111; new_ent.b = imm_sext; new_ent.dest = rt_idx; new_ent.rw = 1'b1; end
      6'h0C: begin new_ent.ctrl = 4'b0000; new_ent.b = imm_zext; new_ent.dest = rt_idx; new_ent.rw = 1'b1; end
      6'h0D: begin new_ent.ctrl = 4'b0001; new_ent.b = imm_zext; new_ent.dest = rt_idx; new_ent.rw = 1'b1; end
      6'h23: begin new_ent.ctrl = 4'b0010; new_ent.b = imm_sext; new_ent.dest = rt_idx; new_ent.rw = 1'b1; end
      6'h2B: begin new_ent.ctrl = 4'b0010; new_ent.b = imm_sext; end
      6'h04: begin new_ent.ctrl = 4'b0110; new_ent.b = rt_val; new_ent.br = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    unique case (state_q)
      EMPTY: if (push) begin main_d = new_ent; state_d = HALF; end
      HALF: begin
        if (push && pop) main_d = new_ent;
        else if (push) begin skid_d = new_ent; state_d = FULL; end
        else if (pop) state_d = EMPTY;
      end
      FULL: if (pop) begin main_d = skid_q; state_d = HALF; end
      default: state_d = EMPTY;
    endcase
    illegal_op_d = accept & ~legal;
    illegal_count_d = illegal_count_q;
    if (illegal_op_d && (illegal_count_q != '1)) illegal_count_d = illegal_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      illegal_op_q <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      illegal_op_q <= illegal_op_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign alu_control = main_q.ctrl;
  assign alu_a = main_q.a;
  assign alu_b = main_q.b;
  assign dest_idx = main_q.dest;
  assign reg_write = main_q.rw;
  assign is_branch = main_q.br;
  assign illegal_op = illegal_op_q;
  assign illegal_count = illegal_count_q;

endmodule
